// File: rtl/mem_if.sv
// mem_if: CPU data-port request/response bundle between cpu (master) and mem_responder (slave).
interface mem_if;
    logic        req;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        err;
    logic        halt;
    logic [31:0] result;
    modport master (output req, memwrite, dataaddr, writedata, input readdata, ready, err, halt, result);
    modport slave  (input req, memwrite, dataaddr, writedata, output readdata, ready, err, halt, result);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: wait-state word RAM responder; define MMIO_EN to map the result/halt register at 0xFFFF_FFF0.
module mem_responder #(
    parameter int    DEPTH_WORDS = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = "memfile.dat"
) (
    input logic  clk,
    input logic  reset,
    mem_if.slave bus
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);
`ifdef MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q, result_q;
    logic          we_q, halt_q;
    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   acc_addr, acc_data, ram_rd;
    logic          acc_we, go_resp, is_mmio, in_range, ok;
    logic [AW-1:0] idx;

    // The access that completes this edge: live inputs when LATENCY==1, otherwise the latched copy.
    always_comb begin
        acc_addr = state == IDLE ? bus.dataaddr : addr_q;
        acc_data = state == IDLE ? bus.writedata : wdata_q;
        acc_we   = state == IDLE ? bus.memwrite : we_q;
        go_resp  = state == IDLE ? bus.req && LATENCY == 1 : state == WAIT && cnt == CW'(1);
        idx      = acc_addr[AW+1:2];
        ram_rd   = ram[idx];
        is_mmio  = MMIO && acc_addr == MMIO_ADDR;
        in_range = acc_addr[1:0] == 2'b00 && {2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS);
        ok       = is_mmio || in_range;
    end

    always_ff @(posedge clk)
        if (!reset && go_resp && acc_we && in_range) ram[idx] <= acc_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            bus.readdata <= '0;
            bus.ready    <= 1'b0;
            bus.err      <= 1'b0;
            halt_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            bus.ready    <= 1'b0;
            bus.err      <= 1'b0;
            bus.readdata <= '0;
            case (state)
                IDLE: if (bus.req) begin
                    addr_q  <= bus.dataaddr;
                    wdata_q <= bus.writedata;
                    we_q    <= bus.memwrite;
                    cnt     <= CW'(LATENCY - 1);
                    state   <= LATENCY == 1 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 1'b1;
                    state <= cnt == CW'(1) ? RESP : WAIT;
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                bus.ready    <= 1'b1;
                bus.err      <= !ok;
                bus.readdata <= ok && !acc_we ? (is_mmio ? result_q : ram_rd) : '0;
                if (is_mmio && acc_we) begin
                    result_q <= acc_data;
                    halt_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.halt   = MMIO & halt_q;
    assign bus.result = MMIO ? result_q : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, store/load, error, reset and MMIO behaviour (LATENCY=2, DEPTH_WORDS=256).
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    mem_if bus();
    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .INIT_FILE("")) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // Drives one request for one edge, then scrambles the inputs so only latched values can matter.
    task automatic access(input logic we, input logic [31:0] a, d, output logic [31:0] rd, output logic e,
                          output int lat, output logic rdy_after, output logic [31:0] rd_after);
        bus.req = 1'b1; bus.memwrite = we; bus.dataaddr = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.memwrite = ~we; bus.dataaddr = 32'h0000_000C; bus.writedata = 32'hBAD0_BAD0;
        lat = 1;
        while (!bus.ready && lat < 10) begin @(posedge clk); #1; lat++; end
        rd = bus.readdata; e = bus.err;
        @(posedge clk); #1;
        rdy_after = bus.ready; rd_after = bus.readdata;
    endtask

    task automatic test_reset;
        vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err); end
        vectors++; if (bus.readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata got %h want 0", bus.readdata); end
        vectors++; if (bus.halt !== 1'b0) begin miscompares++; $display("FAIL reset_halt got %b want 0", bus.halt); end
        vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", bus.result); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, rda; logic e, ra; int lat;
        access(1'b1, 32'h4, 32'd3, rd, e, lat, ra, rda);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL store_latency got %0d want 2", lat); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL store_err got %b want 0", e); end
        vectors++; if (ra !== 1'b0) begin miscompares++; $display("FAIL store_ready_pulse got %b want 0", ra); end
        access(1'b0, 32'h4, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load_latency got %0d want 2", lat); end
        vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL load_0x4 got %h want 3", rd); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL load_err got %b want 0", e); end
        vectors++; if (rda !== 32'h0) begin miscompares++; $display("FAIL load_readdata_after got %h want 0", rda); end
        access(1'b1, 32'h10, 32'hCAFE_F00D, rd, e, lat, ra, rda);
        access(1'b0, 32'h10, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL load_0x10 got %h want cafef00d", rd); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd, rda; logic e, ra; int lat;
        access(1'b1, 32'h6, 32'hDEAD, rd, e, lat, ra, rda);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL misaligned_err got %b want 1", e); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL misaligned_latency got %0d want 2", lat); end
        access(1'b0, 32'h4, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL after_misaligned got %h want 3", rd); end
    endtask

    task automatic test_range;
        logic [31:0] rd, rda; logic e, ra; int lat;
        access(1'b0, 32'h400, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL range_err got %b want 1", e); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL range_readdata got %h want 0", rd); end
        access(1'b1, 32'h3FC, 32'h1234_5678, rd, e, lat, ra, rda);
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL top_word_store_err got %b want 0", e); end
        access(1'b0, 32'h3FC, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL top_word_load got %h want 12345678", rd); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL top_word_load_err got %b want 0", e); end
        access(1'b1, 32'h4000_0004, 32'h99, rd, e, lat, ra, rda);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL high_addr_err got %b want 1", e); end
        access(1'b0, 32'h4, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL no_wrap got %h want 3", rd); end
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd, rda; logic e, ra, seen; int lat;
        access(1'b1, 32'h8, 32'h55, rd, e, lat, ra, rda);
        bus.req = 1'b1; bus.memwrite = 1'b1; bus.dataaddr = 32'h8; bus.writedata = 32'd7;
        @(posedge clk); #1;
        bus.req = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_wait_ready got %b want 0", bus.ready); end
        @(posedge clk); #1 reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1 seen |= bus.ready; end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_wait_spurious_ready got %b want 0", seen); end
        access(1'b0, 32'h8, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (rd !== 32'h55) begin miscompares++; $display("FAIL discarded_store got %h want 55", rd); end
    endtask

    task automatic test_mmio;
        logic [31:0] rd, rda; logic e, ra; int lat;
        access(1'b1, 32'hFFFF_FFF0, 32'd3, rd, e, lat, ra, rda);
`ifdef MMIO_EN
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL mmio_err got %b want 0", e); end
        vectors++; if (bus.halt !== 1'b1) begin miscompares++; $display("FAIL mmio_halt got %b want 1", bus.halt); end
        vectors++; if (bus.result !== 32'd3) begin miscompares++; $display("FAIL mmio_result got %h want 3", bus.result); end
        access(1'b0, 32'hFFFF_FFF0, 32'h0, rd, e, lat, ra, rda);
        vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL mmio_load got %h want 3", rd); end
`else
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL mmio_off_err got %b want 1", e); end
        vectors++; if (bus.halt !== 1'b0) begin miscompares++; $display("FAIL mmio_off_halt got %b want 0", bus.halt); end
        vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("FAIL mmio_off_result got %h want 0", bus.result); end
`endif
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL mmio_latency got %0d want 2", lat); end
    endtask

    task automatic test_reset_resp;
        bus.req = 1'b1; bus.memwrite = 1'b0; bus.dataaddr = 32'h4;
        @(posedge clk); #1 bus.req = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.readdata !== 32'd3) begin miscompares++; $display("FAIL resp_readdata got %h want 3", bus.readdata); end
        #3 reset = 1'b1;
        #1;
        test_reset;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_back_to_back;
        int t;
        bus.req = 1'b1; bus.memwrite = 1'b0; bus.dataaddr = 32'h4;
        t = 0;
        while (!bus.ready && t < 10) begin @(posedge clk); #1 t++; end
        vectors++; if (t !== 2) begin miscompares++; $display("FAIL b2b_first_latency got %0d want 2", t); end
        @(posedge clk); #1 t = 1;
        while (!bus.ready && t < 10) begin @(posedge clk); #1 t++; end
        vectors++; if (t !== 3) begin miscompares++; $display("FAIL b2b_period got %0d want 3", t); end
        vectors++; if (bus.readdata !== 32'd3) begin miscompares++; $display("FAIL b2b_readdata got %h want 3", bus.readdata); end
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req = 1'b0; bus.memwrite = 1'b0; bus.dataaddr = 32'h0; bus.writedata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_store_load;
        test_misaligned;
        test_range;
        test_reset_wait;
        test_mmio;
        test_reset_resp;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
